qos_grant_dispatch: RTL
=======================

Name: qos_grant_dispatch

Overview:
- Consumer end of the QoS arbiter grant interface.
- Takes the arbiter's 4-bit one-hot grant (`out`) each clock and pops one word from the granted virtual-channel (VC) queue.
- Forwards that word to the transmit side through a one-entry output register with a valid/ready handshake.
- Flags malformed or unserviceable grants and keeps saturating per-VC service counters for QoS bandwidth checks.

Parameters:
- DATA_W, 32, width of one VC data word.
- CNT_W, 8, width of each per-VC service counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enb  input  1  dispatch enable; 0 blocks all pops; the output register still drains.
- grant  input  4  one-hot grant from the arbiter; bit i selects VC i.
- vc_valid  input  4  bit i = VC i queue non-empty.
- vc_data  input  4*DATA_W  packed head words; VC i occupies bits [i*DATA_W +: DATA_W].
- vc_pop  output  4  combinational one-hot pop strobe to VC i.
- tx_data  output  DATA_W  registered dispatched word.
- tx_valid  output  1  tx_data holds a word.
- tx_ready  input  1  downstream accepts the word this cycle when high with tx_valid.
- tx_vc  output  2  index of the VC that tx_data came from.
- err_multi  output  1  one-cycle pulse: grant had 2 or more bits set.
- err_empty  output  1  one-cycle pulse: granted VC had vc_valid=0.
- drop  output  1  one-cycle pulse: valid grant discarded because of backpressure.
- svc_cnt  output  4*CNT_W  packed saturating pop counts; VC i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - tx_valid=0, tx_data=0, tx_vc=0.
  - err_multi, err_empty and drop = 0.
  - all svc_cnt = 0; FSM to EMPTY.
  - vc_pop is forced to 0 while reset is high.
- FSM states:
  - EMPTY: tx_valid=0.
  - FULL: tx_valid=1.
- Slot free this cycle: state==EMPTY, or (state==FULL and tx_ready==1).
- Accept condition (all required): enb=1, grant one-hot, vc_valid[i]=1 for granted i, slot free.
  - On accept: vc_pop[i]=1 in the same cycle (combinational from inputs and state).
  - At the next edge: tx_data=vc_data[i], tx_vc=i, state=FULL, svc_cnt[i]+=1.
  - svc_cnt saturates at 2^CNT_W-1; it does not wrap.
- Latency: grant in cycle N gives tx_valid=1 with the word in cycle N+1.
- Back-to-back: a word is dispatched every cycle when tx_ready is held at 1 and grants are valid.
- FULL with tx_ready=1 and no accept: next state EMPTY.
- FULL with tx_ready=1 and accept: stay FULL with the new word; no bubble.
- FULL with tx_ready=0: tx_data and tx_vc hold stable; vc_pop=0.
  - A valid, non-empty grant in this case is discarded and drop pulses at the next edge.
- enb=0: vc_pop=0 and no error or drop pulses. The FSM still handles tx_ready draining.
- grant=0 with enb=1: idle; no pop, no error.
- grant with 2 or more bits set, enb=1: err_multi pulses next cycle; no pop. Error checks take priority over backpressure.
- grant one-hot but vc_valid[i]=0, enb=1: err_empty pulses next cycle; no pop.
- Error and drop outputs are registered. Exactly one of {accept, err_multi, err_empty, drop, none} applies per cycle.
- vc_pop never has more than one bit set.

Test Plan:
- Reset then enb=1, vc_valid=4'b1111, vc_data words 0xA0..0xA3, tx_ready=1, grant sequence 0001,0010,0100,1000 (one per cycle) -> vc_pop mirrors grant the same cycle; tx_data=0xA0,0xA1,0xA2,0xA3 on consecutive cycles; tx_vc=0,1,2,3; svc_cnt all 1.
- Backpressure:
  - tx_ready=0 after the first word, grant=0010 for 3 cycles -> tx_data holds 0xA0, vc_pop=0, drop pulses 3 times.
  - Then tx_ready=1 -> word accepted, then the next grant is dispatched.
- grant=0110 -> err_multi=1 for one cycle, vc_pop=0, counters unchanged. grant=0100 with vc_valid[2]=0 -> err_empty pulse, no pop.
- enb=0 with grant=0001 and vc_valid=1111 -> no pop, no error. A pending word still drains on tx_ready=1.
- CNT_W=2: grant VC3 five times -> svc_cnt[3] stops at 3.
- Reset asserted mid-transfer with tx_valid=1 -> tx_valid=0 immediately (asynchronous), counters 0, vc_pop=0 while reset is high.

Source files
------------

// File: rtl/qos_grant_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : qos_grant_dispatch_if
// Brief    : Grant / VC-queue / transmit bundle for the QoS grant dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
interface qos_grant_dispatch_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic                  enb;
  logic [3:0]            grant;
  logic [3:0]            vc_valid;
  logic [4*DATA_W-1:0]   vc_data;
  logic [3:0]            vc_pop;
  logic [DATA_W-1:0]     tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [1:0]            tx_vc;
  logic                  err_multi;
  logic                  err_empty;
  logic                  drop;
  logic [4*CNT_W-1:0]    svc_cnt;

  modport master (
    output enb, grant, vc_valid, vc_data, tx_ready,
    input  vc_pop, tx_data, tx_valid, tx_vc, err_multi, err_empty, drop, svc_cnt
  );

  modport slave (
    input  enb, grant, vc_valid, vc_data, tx_ready,
    output vc_pop, tx_data, tx_valid, tx_vc, err_multi, err_empty, drop, svc_cnt
  );
endinterface
`default_nettype wire

// File: rtl/qos_grant_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : qos_grant_dispatch
// Brief    : Pops the granted VC queue into a one-entry tx register, flags bad
//            grants and keeps saturating per-VC service counters.
// Revision : 1.0 - initial release
// ============================================================================
module qos_grant_dispatch #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  wire logic            clk,
  input  wire logic            reset,
  qos_grant_dispatch_if.slave  bus
);

  localparam logic [0:0]       S_EMPTY   = 1'b0;
  localparam logic [0:0]       S_FULL    = 1'b1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [0:0]        r_state;
  logic [0:0]        w_next_state;
  logic [DATA_W-1:0] r_tx_data;
  logic [1:0]        r_tx_vc;
  logic              r_err_multi;
  logic              r_err_empty;
  logic              r_drop;

  logic              w_any;
  logic              w_onehot;
  logic              w_hit;
  logic              w_slot_free;
  logic              w_multi;
  logic              w_empty;
  logic              w_drop;
  logic              w_accept;
  logic [1:0]        w_idx;
  logic              w_tx_valid;
  logic [3:0]        w_pop;

  // Grant qualification; the errors never depend on backpressure, which gives them priority.
  always_comb begin
    w_any       = |bus.grant;
    w_onehot    = w_any && ((bus.grant & (bus.grant - 4'd1)) == 4'd0);
    w_hit       = |(bus.grant & bus.vc_valid);
    w_slot_free = (r_state == S_EMPTY) || bus.tx_ready;
    w_multi     = bus.enb && w_any && !w_onehot;
    w_empty     = bus.enb && w_onehot && !w_hit;
    w_drop      = bus.enb && w_onehot && w_hit && !w_slot_free;
    w_accept    = bus.enb && w_onehot && w_hit && w_slot_free && !reset;
    w_idx       = {bus.grant[3] | bus.grant[2], bus.grant[3] | bus.grant[1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_accept)
      w_next_state = S_FULL;
    else if ((r_state == S_FULL) && bus.tx_ready)
      w_next_state = S_EMPTY;
  end

  always_comb begin
    w_tx_valid = (r_state == S_FULL);
    w_pop      = w_accept ? bus.grant : 4'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_data   <= '0;
      r_tx_vc     <= 2'd0;
      r_err_multi <= 1'b0;
      r_err_empty <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_err_multi <= w_multi;
      r_err_empty <= w_empty;
      r_drop      <= w_drop;
      if (w_accept) begin
        r_tx_data <= bus.vc_data[w_idx*DATA_W +: DATA_W];
        r_tx_vc   <= w_idx;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          r_cnt <= '0;
        else if (w_accept && (w_idx == 2'(gi)) && (r_cnt != C_CNT_MAX))
          r_cnt <= r_cnt + CNT_W'(1);
      end
      assign bus.svc_cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

  assign bus.vc_pop    = w_pop;
  assign bus.tx_valid  = w_tx_valid;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_vc     = r_tx_vc;
  assign bus.err_multi = r_err_multi;
  assign bus.err_empty = r_err_empty;
  assign bus.drop      = r_drop;

endmodule
`default_nettype wire
